// File: rtl/nmcu_pkg.sv
// Shared definitions for the nmcu / pool_relu_unit bus masters: default bus widths,
// the dimension-port width derivation, the pooling FSM state type and a signed max helper.
package nmcu_pkg;

  localparam int unsigned NmcuAddrWidth = 16;
  localparam int unsigned NmcuDataWidth = 32;

  // Dimension ports must hold values up to max_dim inclusive.
  function automatic int unsigned dim_width(input int unsigned max_dim);
    return $clog2(max_dim) + 1;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdGap,
    StWrReq,
    StWrGap,
    StFinish
  } pool_state_e;

  // Elements are two's complement; ties keep the accumulator.
  function automatic logic [NmcuDataWidth-1:0] smax(input logic [NmcuDataWidth-1:0] a,
                                                    input logic [NmcuDataWidth-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_relu_unit_if.sv
// Memory bus control signals shared by the nmcu-family bus masters and the memory.
// The data bus itself is a plain inout port so that it resolves as an ordinary net.
interface pool_relu_unit_if
  import nmcu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = NmcuAddrWidth
) ();

  logic                  mem_sel;
  logic                  mem_w;
  logic [ADDR_WIDTH-1:0] address_bus;
  logic                  ready;

  modport master (
    output mem_sel,
    output mem_w,
    output address_bus,
    input  ready
  );

  modport slave (
    input  mem_sel,
    input  mem_w,
    input  address_bus,
    output ready
  );

endinterface

// File: rtl/mem_master_port.sv
// Bus master port: turns a level req/we/addr/wdata request into the sel/w/address/data
// handshake, returns ack/rdata on the ready cycle and forces sel low for the cycle after
// every completed access.
module mem_master_port
  import nmcu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = NmcuAddrWidth,
  parameter int unsigned DATABUS_WIDTH = NmcuDataWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATABUS_WIDTH-1:0] wdata,
  output logic                     ack,
  output logic [DATABUS_WIDTH-1:0] rdata,
  pool_relu_unit_if.master         bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  logic gap_q, gap_d;
  logic sel;

  // Combinational from the requester's state so a reset drops sel immediately.
  assign sel             = req & ~gap_q;
  assign bus.mem_sel     = sel;
  assign bus.mem_w       = sel & we;
  assign bus.address_bus = sel ? addr : '0;
  assign ack             = sel & bus.ready;
  assign rdata           = data_bus;
  assign data_bus        = (sel && we) ? wdata : {DATABUS_WIDTH{1'bz}};

  // Gap request follows every completed access.
  always_comb begin
    gap_d = ack;
  end

  // Gap register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/pool_relu_unit.sv
// 2x2 / stride-2 signed max pooling over a row-major map in shared memory, writing the
// pooled map back to a destination region. Build option POOL_RELU_EN clamps each written
// value at zero; timing and access pattern are identical in both builds.
module pool_relu_unit
  import nmcu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = NmcuAddrWidth,
  parameter int unsigned DATABUS_WIDTH = NmcuDataWidth,
  parameter int unsigned MAX_INPUT_DIM = 15,
  localparam int unsigned DIMW         = dim_width(MAX_INPUT_DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  output logic                     busy,
  input  logic [ADDR_WIDTH-1:0]    src_addr,
  input  logic [ADDR_WIDTH-1:0]    dst_addr,
  input  logic [DIMW-1:0]          in_width,
  input  logic [DIMW-1:0]          in_height,
  pool_relu_unit_if.master         bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  pool_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]    src_q, src_d, dst_q, dst_d;
  logic [DIMW-1:0]          w_q, w_d, out_w_q, out_w_d, out_h_q, out_h_d;
  logic [DIMW-1:0]          ox_q, ox_d, oy_q, oy_d;
  logic [1:0]               rd_idx_q, rd_idx_d;  // {dy, dx} of the next read
  logic [DATABUS_WIDTH-1:0] acc_q, acc_d;
  logic                     done_q, done_d;

  logic                     req, we, ack;
  logic [ADDR_WIDTH-1:0]    mem_addr, rd_addr, wr_addr;
  logic [DATABUS_WIDTH-1:0] rdata, wdata;
  logic [DIMW:0]            row, col;
  logic                     last_win;

  // Window element and output addresses, all wrapping at ADDR_WIDTH bits.
  always_comb begin
    row      = {oy_q, rd_idx_q[1]};
    col      = {ox_q, rd_idx_q[0]};
    rd_addr  = src_q + ADDR_WIDTH'(row) * ADDR_WIDTH'(w_q) + ADDR_WIDTH'(col);
    wr_addr  = dst_q + ADDR_WIDTH'(oy_q) * ADDR_WIDTH'(out_w_q) + ADDR_WIDTH'(ox_q);
    last_win = (ox_q == out_w_q - DIMW'(1)) && (oy_q == out_h_q - DIMW'(1));
`ifdef POOL_RELU_EN
    wdata    = acc_q[DATABUS_WIDTH-1] ? '0 : acc_q;
`else
    wdata    = acc_q;
`endif
  end

  // Pooling FSM next state, datapath updates and bus request.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    w_d      = w_q;
    out_w_d  = out_w_q;
    out_h_d  = out_h_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    rd_idx_d = rd_idx_q;
    acc_d    = acc_q;
    done_d   = done_q;
    req      = 1'b0;
    we       = 1'b0;
    mem_addr = rd_addr;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d    = src_addr;
          dst_d    = dst_addr;
          w_d      = in_width;
          out_w_d  = in_width >> 1;
          out_h_d  = in_height >> 1;
          ox_d     = '0;
          oy_d     = '0;
          rd_idx_d = '0;
          done_d   = 1'b0;
          // An empty output map finishes without touching the bus.
          if (in_width < DIMW'(2) || in_height < DIMW'(2)) begin
            state_d = StFinish;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        req = 1'b1;
        if (ack) begin
          acc_d    = (rd_idx_q == 2'd0) ? rdata : smax(acc_q, rdata);
          rd_idx_d = rd_idx_q + 2'd1;
          state_d  = StRdGap;
        end
      end
      StRdGap: begin
        // rd_idx wraps to zero once all four window elements are in.
        state_d = (rd_idx_q == 2'd0) ? StWrReq : StRdReq;
      end
      StWrReq: begin
        req      = 1'b1;
        we       = 1'b1;
        mem_addr = wr_addr;
        if (ack) begin
          state_d = StWrGap;
        end
      end
      StWrGap: begin
        if (last_win) begin
          state_d = StFinish;
        end else begin
          if (ox_q == out_w_q - DIMW'(1)) begin
            ox_d = '0;
            oy_d = oy_q + DIMW'(1);
          end else begin
            ox_d = ox_q + DIMW'(1);
          end
          state_d = StRdReq;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StFinish) begin
      done_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      w_q      <= '0;
      out_w_q  <= '0;
      out_h_q  <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      rd_idx_q <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      w_q      <= w_d;
      out_w_q  <= out_w_d;
      out_h_q  <= out_h_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      rd_idx_q <= rd_idx_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign busy = (state_q != StIdle) && (state_q != StFinish);

  mem_master_port #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATABUS_WIDTH(DATABUS_WIDTH)
  ) u_port (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .addr    (mem_addr),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata),
    .bus     (bus),
    .data_bus(data_bus)
  );

endmodule

// File: tb/tb_pool_relu_unit.sv
// Self-checking bench for pool_relu_unit: latency-2 memory model, expected writes and
// read addresses queued from a reference pooling model, observations compared per test.
module tb_pool_relu_unit;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic        busy;
  logic [15:0] src_addr, dst_addr;
  logic [4:0]  in_width, in_height;
  wire  [31:0] data_bus;

  pool_relu_unit_if #(.ADDR_WIDTH(16)) bus ();

  pool_relu_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .busy     (busy),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .in_width (in_width),
    .in_height(in_height),
    .bus      (bus),
    .data_bus (data_bus)
  );

  always #5 clk = ~clk;

  // Memory: read-only storage, written by the bench; DUT writes are observed on the bus.
  logic [31:0] mem [0:65535];
  int          lat_cnt;

  assign data_bus = (bus.mem_sel && !bus.mem_w) ? mem[bus.address_bus] : 32'hzzzz_zzzz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ready <= 1'b0;
      lat_cnt   <= 0;
    end else if (bus.mem_sel && !bus.ready) begin
      if (lat_cnt == LATENCY - 1) begin
        bus.ready <= 1'b1;
        lat_cnt   <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      bus.ready <= 1'b0;
      lat_cnt   <= 0;
    end
  end

  int errors = 0;
  int checks = 0;

  // Scoreboard queues.
  logic [15:0] exp_wr_addr[$], obs_wr_addr[$], exp_rd_addr[$], obs_rd_addr[$];
  logic [31:0] exp_wr_data[$], obs_wr_data[$];
  int          n_acc, n_sel, op_cycles;
  logic        timed_out, first_busy;

  // Reference model: queue expected read addresses and pooled writes.
  task automatic build_expect(input logic [15:0] s, input logic [15:0] d, input int w,
                              input int h);
    int ow = w / 2;
    int oh = h / 2;
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        logic signed [31:0] m = 0;
        for (int k = 0; k < 4; k++) begin
          logic [15:0] a = s + 16'((2 * oy + k / 2) * w + 2 * ox + k % 2);
          exp_rd_addr.push_back(a);
          if (k == 0 || $signed(mem[a]) > m) m = $signed(mem[a]);
        end
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_wr_addr.push_back(d + 16'(oy * ow + ox));
        exp_wr_data.push_back(m);
      end
    end
  endtask

  // Pulse start, scramble the inputs afterwards, and record bus activity until done.
  task automatic run_op(input logic [15:0] s, input logic [15:0] d, input logic [4:0] w,
                        input logic [4:0] h);
    logic prev_sel = 1'b0;
    int   cyc = 1;
    obs_wr_addr.delete(); obs_wr_data.delete(); obs_rd_addr.delete();
    n_acc = 0; n_sel = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; in_width = w; in_height = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_addr = 16'hDEAD; dst_addr = 16'hBEEF; in_width = 5'd1; in_height = 5'd1;
    first_busy = busy;
    while (cyc < 3000) begin
      if (bus.mem_sel && !prev_sel) n_sel++;
      prev_sel = bus.mem_sel;
      if (bus.mem_sel && bus.ready) begin
        n_acc++;
        if (bus.mem_w) begin
          obs_wr_addr.push_back(bus.address_bus);
          obs_wr_data.push_back(data_bus);
        end else begin
          obs_rd_addr.push_back(bus.address_bus);
        end
      end
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    op_cycles = cyc;
    timed_out = !done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.mem_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", bus.mem_sel); end
    checks++; if (bus.mem_w !== 1'b0) begin errors++; $display("FAIL reset_w: got %b want 0", bus.mem_w); end
    checks++; if (bus.address_bus !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.address_bus); end
  endtask

  task automatic test_pool_4x4();
    for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 32'(i + 1);
    build_expect(16'h0100, 16'h0200, 4, 4);
    run_op(16'h0100, 16'h0200, 5'd4, 5'd4);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL p4_timeout: got %b want 0", timed_out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL p4_done: got %b want 1", done); end
    checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL p4_busy: got %b want 1", first_busy); end
    checks++; if (n_acc !== 20) begin errors++; $display("FAIL p4_accesses: got %0d want 20", n_acc); end
    checks++; if (n_sel !== 20) begin errors++; $display("FAIL p4_sel_pulses: got %0d want 20", n_sel); end
    checks++; if (obs_wr_addr.size() !== exp_wr_addr.size()) begin errors++; $display("FAIL p4_nwrites: got %0d want %0d", obs_wr_addr.size(), exp_wr_addr.size()); end
    while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
      logic [15:0] ea = exp_wr_addr.pop_front(), oa = obs_wr_addr.pop_front();
      logic [31:0] ed = exp_wr_data.pop_front(), od = obs_wr_data.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL p4_waddr: got %h want %h", oa, ea); end
      checks++; if (od !== ed) begin errors++; $display("FAIL p4_wdata: got %0d want %0d", $signed(od), $signed(ed)); end
    end
  endtask

  task automatic test_odd_5x3();
    for (int i = 0; i < 15; i++) mem[16'h0800 + 16'(i)] = 32'(i + 1);
    build_expect(16'h0800, 16'h0900, 5, 3);
    run_op(16'h0800, 16'h0900, 5'd5, 5'd3);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL odd_timeout: got %b want 0", timed_out); end
    checks++; if (n_acc !== 10) begin errors++; $display("FAIL odd_accesses: got %0d want 10", n_acc); end
    checks++; if (obs_rd_addr.size() !== exp_rd_addr.size()) begin errors++; $display("FAIL odd_nreads: got %0d want %0d", obs_rd_addr.size(), exp_rd_addr.size()); end
    while (exp_rd_addr.size() > 0 && obs_rd_addr.size() > 0) begin
      logic [15:0] ea = exp_rd_addr.pop_front(), oa = obs_rd_addr.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL odd_raddr: got %h want %h", oa, ea); end
    end
    checks++; if (obs_wr_addr.size() !== 2) begin errors++; $display("FAIL odd_nwrites: got %0d want 2", obs_wr_addr.size()); end
    while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
      logic [15:0] ea = exp_wr_addr.pop_front(), oa = obs_wr_addr.pop_front();
      logic [31:0] ed = exp_wr_data.pop_front(), od = obs_wr_data.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL odd_waddr: got %h want %h", oa, ea); end
      checks++; if (od !== ed) begin errors++; $display("FAIL odd_wdata: got %0d want %0d", $signed(od), $signed(ed)); end
    end
  endtask

  // Window maxima land on the 1st, 2nd and 3rd element; negatives exercise signed compare.
  task automatic test_signed_max();
    int vals[12] = '{7, -2, -1, 100, -6, -7, 3, -8, -50, 2, -3, -9};
    for (int i = 0; i < 12; i++) mem[16'h0400 + 16'(i)] = 32'(vals[i]);
    mem[16'h0500] = -5; mem[16'h0501] = -3; mem[16'h0502] = -9; mem[16'h0503] = -1;
    build_expect(16'h0400, 16'h0480, 6, 2);
    run_op(16'h0400, 16'h0480, 5'd6, 5'd2);
    checks++; if (obs_wr_addr.size() !== 3) begin errors++; $display("FAIL smax_nwrites: got %0d want 3", obs_wr_addr.size()); end
    while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
      logic [15:0] ea = exp_wr_addr.pop_front(), oa = obs_wr_addr.pop_front();
      logic [31:0] ed = exp_wr_data.pop_front(), od = obs_wr_data.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL smax_waddr: got %h want %h", oa, ea); end
      checks++; if (od !== ed) begin errors++; $display("FAIL smax_wdata: got %0d want %0d", $signed(od), $signed(ed)); end
    end
    // Window {-5,-3,-9,-1}: -1 plain, 0 when clamped.
    run_op(16'h0500, 16'h0580, 5'd2, 5'd2);
    checks++; if (obs_wr_data.size() !== 1) begin errors++; $display("FAIL mixed_nwrites: got %0d want 1", obs_wr_data.size()); end
    else begin
`ifdef POOL_RELU_EN
      checks++; if (obs_wr_data[0] !== 32'd0) begin errors++; $display("FAIL mixed_relu: got %0d want 0", $signed(obs_wr_data[0])); end
`else
      checks++; if (obs_wr_data[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mixed_plain: got %0d want -1", $signed(obs_wr_data[0])); end
`endif
    end
  endtask

  task automatic test_degenerate();
    run_op(16'h0100, 16'h0600, 5'd1, 5'd4);
    checks++; if (op_cycles !== 1) begin errors++; $display("FAIL degen_latency: got %0d want 1", op_cycles); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL degen_done: got %b want 1", done); end
    checks++; if (n_sel !== 0) begin errors++; $display("FAIL degen_sel: got %0d want 0", n_sel); end
    checks++; if (first_busy !== 1'b0) begin errors++; $display("FAIL degen_busy: got %b want 0", first_busy); end
  endtask

  // Pooling a conv result left at 0x0200 by the preceding stage.
  task automatic test_chain();
    mem[16'h0200] = 348; mem[16'h0201] = 393; mem[16'h0202] = 528; mem[16'h0203] = 573;
    run_op(16'h0200, 16'h0300, 5'd2, 5'd2);
    checks++; if (n_acc !== 5) begin errors++; $display("FAIL chain_accesses: got %0d want 5", n_acc); end
    checks++; if (obs_wr_addr.size() !== 1) begin errors++; $display("FAIL chain_nwrites: got %0d want 1", obs_wr_addr.size()); end
    else begin
      checks++; if (obs_wr_addr[0] !== 16'h0300) begin errors++; $display("FAIL chain_waddr: got %h want 0300", obs_wr_addr[0]); end
      checks++; if (obs_wr_data[0] !== 32'd573) begin errors++; $display("FAIL chain_wdata: got %0d want 573", obs_wr_data[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int   writes = 0;
    int   cyc = 0;
    logic hit = 1'b0;
    @(negedge clk);
    src_addr = 16'h0100; dst_addr = 16'h0200; in_width = 5'd4; in_height = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 2000) begin
      if (bus.mem_sel && bus.mem_w && bus.ready) writes++;
      if (writes == 1 && bus.mem_sel && !bus.mem_w) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rmid_reach: got %b want 1", hit); end
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_sel !== 1'b0) begin errors++; $display("FAIL rmid_sel: got %b want 0", bus.mem_sel); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    build_expect(16'h0100, 16'h0200, 4, 4);
    run_op(16'h0100, 16'h0200, 5'd4, 5'd4);
    checks++; if (n_acc !== 20) begin errors++; $display("FAIL rmid_re_accesses: got %0d want 20", n_acc); end
    while (exp_wr_addr.size() > 0 && obs_wr_addr.size() > 0) begin
      logic [15:0] ea = exp_wr_addr.pop_front(), oa = obs_wr_addr.pop_front();
      logic [31:0] ed = exp_wr_data.pop_front(), od = obs_wr_data.pop_front();
      checks++; if (oa !== ea) begin errors++; $display("FAIL rmid_waddr: got %h want %h", oa, ea); end
      checks++; if (od !== ed) begin errors++; $display("FAIL rmid_wdata: got %0d want %0d", $signed(od), $signed(ed)); end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    src_addr = '0; dst_addr = '0; in_width = '0; in_height = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_pool_4x4();
    test_odd_5x3();
    test_signed_max();
    test_degenerate();
    test_chain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_relu_unit.md
Name: pool_relu_unit

Overview:
Post-processing stage directly downstream of nmcu. Once nmcu has written a convolution output map to memory, this block reads it back over the shared memory bus and applies 2x2/stride-2 max pooling, with optional ReLU. It writes the pooled map to a destination region. It is a bus master on the same sel/w_en/address_bus/data_bus/ready protocol as nmcu, and is started by the controller after nmcu's done.

Parameters:
ADDR_WIDTH, 16, memory address width
DATABUS_WIDTH, 32, data word width; elements are signed two's complement
MAX_INPUT_DIM, 15, maximum map width/height; dimension ports are $clog2(MAX_INPUT_DIM)+1 bits (5 at default)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
done  out  1  operation complete; held high until next accepted start
busy  out  1  high from accepted start until done rises
src_addr  in  ADDR_WIDTH  base address of input map (row-major)
dst_addr  in  ADDR_WIDTH  base address of pooled output map (row-major)
in_width  in  DIMW  input map width
in_height  in  DIMW  input map height
mem_sel  out  1  bus request
mem_w  out  1  1 = write, 0 = read; valid while mem_sel is high
address_bus  out  ADDR_WIDTH  access address
data_bus  inout  DATABUS_WIDTH  driven only while mem_sel && mem_w, else high-Z
ready  in  1  memory completion strobe

Behaviour:
- Reset (rst low, asynchronous): state IDLE. done=0, busy=0, mem_sel=0, mem_w=0, address_bus=0, data_bus=Z. All counters and the accumulator are cleared.
- Input sampling: dimensions and addresses are latched on the accepted start. Later changes to these inputs are ignored until the next start.
- Output geometry: out_w=floor(in_width/2), out_h=floor(in_height/2). An odd last row or column is dropped.
- Window read addresses, window (ox,oy): src_addr + (2oy+dy)*in_width + (2ox+dx), for dy,dx in {0,1}. Read order is (0,0),(0,1),(1,0),(1,1).
- Write address: dst_addr + oy*out_w + ox. Windows are processed row-major, ox fastest.
- Address arithmetic is ADDR_WIDTH-bit and wraps modulo 2^ADDR_WIDTH with no error.
- Bus handshake:
  - Master raises mem_sel with address/mem_w (and data if writing) stable.
  - All are held until the first cycle ready=1. On a read, data_bus is captured in that cycle.
  - mem_sel drops for exactly one cycle after each completed access before the next request.
- Max: signed compare. The first read of a window loads the accumulator; the next three update it as max(acc, word).
- State machine:
  - IDLE: if start, latch inputs.
    - If in_width<2 or in_height<2: go to FINISH with zero bus accesses.
    - Otherwise: busy=1, go to RD_REQ.
  - RD_REQ: sel=1, w=0. On ready, capture/update; go to RD_GAP.
  - RD_GAP: sel=0. Go to WR_REQ after the 4th read, else back to RD_REQ.
  - WR_REQ: sel=1, w=1, drive the result. On ready, go to WR_GAP.
  - WR_GAP: sel=0. If this was the last window, go to FINISH; else advance ox/oy and go to RD_REQ.
  - FINISH: done=1, busy=0. Go to IDLE in the next cycle; done stays high in IDLE until the next accepted start clears it.
- start while busy is ignored. start held high across completion restarts the operation immediately from IDLE; the bench pulses start.
- Reset mid-operation: mem_sel drops asynchronously, no partial write completes, and the output region may be partially written.
- Access count: exactly 5*out_w*out_h bus accesses per operation.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: each written value is max(result, 0); a negative pooled value writes 0.
- Undefined: the pooled value is written unmodified, signed.
- Timing and access count are identical in both builds.

Decomposition:
- Shared package nmcu_pkg holds:
  - the bus width constants (ADDR_WIDTH/DATABUS_WIDTH defaults)
  - the DIMW derivation
  - the state enum for this block
  - a signed max helper function
- One sub-module, mem_master_port, owns the sel/w/address/tristate/ready handshake and the one-cycle gap. It presents req/we/addr/wdata in and ack/rdata out to the pooling FSM.

Test Plan:
- 4x4 input values 1..16 at 0x0100, dst 0x0200, memory LATENCY=2 -> 2x2 output 6,8,14,16; exactly 20 accesses; done=1.
- 5x3 input values 1..15 -> 2x1 output 7,9; row 3 and column 5 unread (address monitor).
- Mixed signs, window {-5,-3,-9,-1}: without POOL_RELU_EN -> -1 written; with POOL_RELU_EN -> 0 written.
- in_width=1, in_height=4 -> done next cycle after start, zero mem_sel assertions.
- Chain test: nmcu 4x4 input with 3x3 kernel 1..9 produces 2x2 {348,393,528,573} at 0x0200; pool with src 0x0200, 2x2 -> single output 573.
- rst low during the 2nd window's RD_REQ -> mem_sel low within the same cycle, done=0, busy=0; a fresh start completes correctly.
